sata_axil_regfile: RTL and testbench

SATA_AXIL_REGFILE -- requirements
Module: sata_axil_regfile

---
 rtl/sata_axil_regfile.sv | 201 ++++++++++++++++++++
 tb/tb_sata_axil_regfile.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_axil_regfile.sv
// AXI4-Lite register file: RW control registers, RO status inputs, and a sticky
// W1C interrupt status register with enable mask driving a registered irq.
module sata_axil_regfile #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_RW_REGS        = 8,
  parameter int unsigned NUM_RO_REGS        = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RW_RESET_VALUE = '0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_regs_o,
  output logic [NUM_RW_REGS-1:0]                 rw_wr_stb_o,
  input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*C_S_AXI_DATA_WIDTH-1:0] ro_regs_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          int_event_i,
  output logic                                   irq_o
);

  localparam int unsigned DW        = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW        = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB        = DW / 8;
  localparam int unsigned ADDR_LSB  = (DW == 64) ? 3 : 2;
  localparam int unsigned IW        = AW - ADDR_LSB;
  localparam int unsigned IDX_ISTAT = NUM_RW_REGS + NUM_RO_REGS;
  localparam int unsigned IDX_IEN   = IDX_ISTAT + 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                              aw_held_q, w_held_q;
  logic [IW-1:0]                     aw_idx_q;
  logic [DW-1:0]                     wdata_q;
  logic [NB-1:0]                     wstrb_q;
  logic                              bvalid_q, rvalid_q, irq_q;
  logic [1:0]                        bresp_q, rresp_q;
  logic [DW-1:0]                     rdata_q;
  logic [NUM_RW_REGS-1:0][DW-1:0]    rw_q, rw_d;
  logic [NUM_RW_REGS-1:0]            wr_stb_q, wr_stb_d;
  logic [DW-1:0]                     int_status_q, int_status_d;
  logic [DW-1:0]                     int_enable_q, int_enable_d;
  logic [DW-1:0]                     byte_mask, istat_clr, rd_data;
  logic [1:0]                        wr_resp, rd_resp;
  int unsigned                       wr_idx, rd_idx;
  logic                              aw_hs, w_hs, ar_hs, commit;

  assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = S_AXI_ARESETN & (~rvalid_q | S_AXI_RREADY);

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held_q & w_held_q;

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign rw_regs_o    = rw_q;
  assign rw_wr_stb_o  = wr_stb_q;
  assign irq_o        = irq_q;

  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      byte_mask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
  end

  // Write decode; resp is computed from the held index and only used on commit.
  always_comb begin
    wr_idx       = 32'(aw_idx_q);
    rw_d         = rw_q;
    wr_stb_d     = '0;
    int_enable_d = int_enable_q;
    istat_clr    = '0;
    wr_resp      = RESP_SLVERR;
    for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
      if (wr_idx == i) begin
        wr_resp = RESP_OKAY;
        if (commit) begin
          rw_d[i]     = (rw_q[i] & ~byte_mask) | (wdata_q & byte_mask);
          wr_stb_d[i] = |wstrb_q;
        end
      end
    end
    if (wr_idx >= NUM_RW_REGS && wr_idx < IDX_ISTAT) begin
      wr_resp = RESP_OKAY;
    end
    if (wr_idx == IDX_ISTAT) begin
      wr_resp = RESP_OKAY;
      if (commit) istat_clr = wdata_q & byte_mask;
    end
    if (wr_idx == IDX_IEN) begin
      wr_resp = RESP_OKAY;
      if (commit) int_enable_d = (int_enable_q & ~byte_mask) | (wdata_q & byte_mask);
    end
    // A new event in the same cycle as a clear keeps its bit set.
    int_status_d = (int_status_q & ~istat_clr) | int_event_i;
  end

  always_comb begin
    rd_idx  = 32'(S_AXI_ARADDR[AW-1:ADDR_LSB]);
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
      if (rd_idx == i) begin
        rd_data = rw_q[i];
        rd_resp = RESP_OKAY;
      end
    end
    for (int unsigned j = 0; j < NUM_RO_REGS; j++) begin
      if (rd_idx == NUM_RW_REGS + j) begin
        rd_data = ro_regs_i[j*DW +: DW];
        rd_resp = RESP_OKAY;
      end
    end
    if (rd_idx == IDX_ISTAT) begin
      rd_data = int_status_q;
      rd_resp = RESP_OKAY;
    end
    if (rd_idx == IDX_IEN) begin
      rd_data = int_enable_q;
      rd_resp = RESP_OKAY;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      rw_q         <= {NUM_RW_REGS{RW_RESET_VALUE}};
      wr_stb_q     <= '0;
      int_status_q <= '0;
      int_enable_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[AW-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      rw_q         <= rw_d;
      wr_stb_q     <= wr_stb_d;
      int_status_q <= int_status_d;
      int_enable_q <= int_enable_d;
      irq_q        <= |(int_status_q & int_enable_q);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0], ro_regs_i};

endmodule

// File: tb/tb_sata_axil_regfile.sv
// Bench for sata_axil_regfile: a 32-bit default instance and a 64-bit, 4 RW / 0 RO
// instance share stimulus; sel picks which one is driven and observed.
module tb_sata_axil_regfile;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        sel;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [63:0] wdata, int_event;
  logic [7:0]  wstrb;

  logic        awready32, wready32, bvalid32, arready32, rvalid32, irq32;
  logic [1:0]  bresp32, rresp32;
  logic [31:0] rdata32;
  logic [255:0] rw32;
  logic [7:0]  stb32;
  logic        awready64, wready64, bvalid64, arready64, rvalid64, irq64;
  logic [1:0]  bresp64, rresp64;
  logic [63:0] rdata64;
  logic [255:0] rw64;
  logic [3:0]  stb64;

  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;
  logic [7:0]  stb;

  localparam logic [127:0] RO32 = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

  always #5 clk = ~clk;

  sata_axil_regfile u_dut32 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & ~sel),
    .S_AXI_AWREADY(awready32),
    .S_AXI_WDATA(wdata[31:0]), .S_AXI_WSTRB(wstrb[3:0]), .S_AXI_WVALID(wvalid & ~sel),
    .S_AXI_WREADY(wready32),
    .S_AXI_BRESP(bresp32), .S_AXI_BVALID(bvalid32), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & ~sel),
    .S_AXI_ARREADY(arready32),
    .S_AXI_RDATA(rdata32), .S_AXI_RRESP(rresp32), .S_AXI_RVALID(rvalid32),
    .S_AXI_RREADY(rready),
    .rw_regs_o(rw32), .rw_wr_stb_o(stb32), .ro_regs_i(RO32),
    .int_event_i(sel ? 32'h0 : int_event[31:0]), .irq_o(irq32)
  );

  sata_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(64), .NUM_RW_REGS(4), .NUM_RO_REGS(0)
  ) u_dut64 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & sel),
    .S_AXI_AWREADY(awready64),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid & sel),
    .S_AXI_WREADY(wready64),
    .S_AXI_BRESP(bresp64), .S_AXI_BVALID(bvalid64), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & sel),
    .S_AXI_ARREADY(arready64),
    .S_AXI_RDATA(rdata64), .S_AXI_RRESP(rresp64), .S_AXI_RVALID(rvalid64),
    .S_AXI_RREADY(rready),
    .rw_regs_o(rw64), .rw_wr_stb_o(stb64), .ro_regs_i(64'h0),
    .int_event_i(sel ? int_event : 64'h0), .irq_o(irq64)
  );

  always_comb begin
    if (sel) begin
      awready = awready64; wready = wready64; bvalid = bvalid64; bresp = bresp64;
      arready = arready64; rvalid = rvalid64; rresp = rresp64; rdata = rdata64;
      irq = irq64; stb = {4'h0, stb64};
    end else begin
      awready = awready32; wready = wready32; bvalid = bvalid32; bresp = bresp32;
      arready = arready32; rvalid = rvalid32; rresp = rresp32; rdata = {32'h0, rdata32};
      irq = irq32; stb = stb32;
    end
  end

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          lsb, nrw, nro, ist, ien;
  logic [63:0] exp_rw[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout/unexpected expected handshake", tag);
  endtask

  function automatic logic [7:0] ad(input int idx);
    return 8'(idx << lsb);
  endfunction

  function automatic logic [63:0] get_rw(input int i);
    return sel ? rw64[i*64 +: 64] : {32'h0, rw32[i*32 +: 32]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < (sel ? 8 : 4); b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic check_all_rw();
    for (int i = 0; i < nrw; i++) check($sformatf("rw_reg%0d", i), get_rw(i), exp_rw[i]);
  endtask

  // Scoreboard: pop on each R/B beat that will handshake at the next rising edge.
  always @(negedge clk) begin
    if (arst_n) begin
      if (rvalid && rready) begin
        if (rq.size() == 0) fail_now("unexpected_r");
        else begin
          rexp_t e;
          e = rq.pop_front();
          check("rdata", rdata, e.d);
          check("rresp", {62'h0, rresp}, {62'h0, e.r});
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) fail_now("unexpected_b");
        else check("bresp", {62'h0, bresp}, {62'h0, bq.pop_front()});
      end
    end
  end

  task automatic do_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int lead, input logic [1:0] eresp);
    bit w_done = 1'b0, aw_done = 1'b0, w_hs, aw_hs;
    int cyc = 0;
    bq.push_back(eresp);
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(w_done && aw_done) && cyc < 100) begin
      if (cyc >= lead && !aw_done) begin awaddr = a; awvalid = 1'b1; end
      w_hs  = wvalid && wready;
      aw_hs = awvalid && awready;
      @(posedge clk); #1; cyc++;
      if (w_hs)  begin w_done = 1'b1;  wvalid = 1'b0;  end
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
    end
    if (!(w_done && aw_done)) fail_now("write_handshake");
  endtask

  task automatic issue_read(input logic [7:0] a, input logic [63:0] d, input logic [1:0] r);
    int n = 0;
    rq.push_back('{d: d, r: r});
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    if (!arready) fail_now("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_suite(input logic s);
    logic [63:0] v0, third_exp;
    int third_idx, edges;
    sel = s;
    lsb = s ? 3 : 2; nrw = s ? 4 : 8; nro = s ? 0 : 4;
    ist = nrw + nro; ien = ist + 1;
    for (int i = 0; i < 8; i++) exp_rw[i] = 64'h0;
    idle(1);

    // W leads AW by three cycles, two low bytes strobed.
    do_write(ad(2), 64'hA5A5_1234, 8'h03, 3, 2'b00);
    exp_rw[2] = merge(exp_rw[2], 64'hA5A5_1234, 8'h03);
    idle(1);
    check("wr_stb_pulse", {56'h0, stb}, 64'h04);
    check("reg2_value", get_rw(2), 64'h1234);
    idle(1);
    check("wr_stb_clear", {56'h0, stb}, 64'h0);
    check_all_rw();

    // Unmapped index 31.
    do_write(ad(31), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 2'b10);
    idle(3);
    check("unmapped_no_stb", {56'h0, stb}, 64'h0);
    check_all_rw();
    issue_read(ad(31), 64'h0, 2'b10);
    idle(1);

    // Interrupt: enable bit 5, pulse event, W1C, then W1C against a live event.
    do_write(ad(ien), 64'h20, 8'hFF, 0, 2'b00);
    idle(2);
    int_event = 64'h20; idle(1); int_event = 64'h0;
    idle(1);
    check("irq_set", {63'h0, irq}, 64'h1);
    issue_read(ad(ist), 64'h20, 2'b00);
    do_write(ad(ist), 64'h20, 8'h01, 0, 2'b00);
    idle(1);
    check("irq_commit_cycle", {63'h0, irq}, 64'h1);
    idle(1);
    check("irq_cleared", {63'h0, irq}, 64'h0);
    issue_read(ad(ist), 64'h0, 2'b00);
    int_event = 64'h20;
    do_write(ad(ist), 64'h20, 8'h01, 0, 2'b00);
    idle(2);
    int_event = 64'h0;
    idle(1);
    check("irq_event_wins", {63'h0, irq}, 64'h1);
    issue_read(ad(ist), 64'h20, 2'b00);

    // Back-to-back reads with RREADY held high.
    v0 = 64'h0123_4567_89AB_CDEF;
    do_write(ad(0), v0, 8'hFF, 1, 2'b00);
    exp_rw[0] = merge(exp_rw[0], v0, 8'hFF);
    idle(2);
    check_all_rw();
    third_idx = s ? ien : nrw + 1;
    third_exp = s ? 64'h20 : 64'hC0DE_0001;
    rready = 1'b1;
    edges = 0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      logic [63:0] e;
      logic [1:0] r;
      idx = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? third_idx : 31;
      e = (k == 0) ? exp_rw[0] : (k == 1) ? exp_rw[2] : (k == 2) ? third_exp : 64'h0;
      r = (k == 3) ? 2'b10 : 2'b00;
      rq.push_back('{d: e, r: r});
      araddr = ad(idx); arvalid = 1'b1;
      for (int n = 0; n < 20 && !arready; n++) begin @(posedge clk); #1; edges++; end
      @(posedge clk); #1; edges++;
      check("b2b_rvalid", {63'h0, rvalid}, 64'h1);
    end
    arvalid = 1'b0;
    check("b2b_cycles", 64'(edges), 64'd4);
    idle(1);
    check("b2b_rvalid_end", {63'h0, rvalid}, 64'h0);

    // Stall: RREADY low for five cycles.
    rready = 1'b0;
    issue_read(ad(2), exp_rw[2], 2'b00);
    arvalid = 1'b1; araddr = ad(0);
    for (int c = 0; c < 5; c++) begin
      check("stall_rvalid", {63'h0, rvalid}, 64'h1);
      check("stall_arready", {63'h0, arready}, 64'h0);
      check("stall_rdata", rdata, exp_rw[2]);
      idle(1);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    idle(2);
  endtask

  initial begin
    arst_n = 1'b1; sel = 1'b0;
    awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; int_event = '0; bready = 1'b1; rready = 1'b1;
    lsb = 2; nrw = 8; nro = 4; ist = 12; ien = 13;
    #1 arst_n = 1'b0;
    idle(3);
    check("rst_awready", {63'h0, awready}, 64'h0);
    check("rst_wready", {63'h0, wready}, 64'h0);
    check("rst_arready", {63'h0, arready}, 64'h0);
    check("rst_bvalid", {63'h0, bvalid}, 64'h0);
    check("rst_rvalid", {63'h0, rvalid}, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_reg0", get_rw(0), 64'h0);
    arst_n = 1'b1;
    #1 check("post_rst_awready", {63'h0, awready}, 64'h1);
    idle(1);

    run_suite(1'b0);
    run_suite(1'b1);

    // Reset while a write response is pending.
    sel = 1'b0; lsb = 2; nrw = 8;
    bready = 1'b0;
    do_write(ad(2), 64'h77, 8'hFF, 0, 2'b00);
    for (int n = 0; n < 20 && !bvalid; n++) idle(1);
    check("pre_rst_bvalid", {63'h0, bvalid}, 64'h1);
    #2 arst_n = 1'b0;
    #1;
    check("async_bvalid", {63'h0, bvalid}, 64'h0);
    check("async_irq", {63'h0, irq}, 64'h0);
    check("async_reg2", get_rw(2), 64'h0);
    check("async_awready", {63'h0, awready}, 64'h0);
    bq.delete();
    @(posedge clk); #1;
    arst_n = 1'b1;
    bready = 1'b1;
    idle(10);
    check("no_late_bvalid", {63'h0, bvalid}, 64'h0);
    issue_read(ad(2), 64'h0, 2'b00);
    idle(2);
    check("rq_drained", 64'(rq.size()), 64'd0);
    check("bq_drained", 64'(bq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
